// File: rtl/pipe_defs.sv
// Shared pipeline definitions for the forwarding/hazard logic:
// latency classes, forward-select encoding and select-width helper.
package pipe_defs;

    localparam int unsigned LAT_ALU  = 0;
    localparam int unsigned LAT_LOAD = 1;
    localparam int unsigned FWD_RF   = 0;

    // Select width covering "register file" plus one code per forwardable slot
    function automatic int unsigned sel_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match_lane.sv
// One source operand's hazard lane: finds the youngest in-flight writer of rs
// and reports its forward select and whether its result is not yet available.
module fwd_match_lane
    import pipe_defs::*;
#(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned LAT_W  = 2,
    parameter int unsigned SEL_W  = 2
) (
    input  logic [REG_AW-1:0]       rs_i,
    input  logic                    used_i,
    input  logic [DEPTH-1:0]        slot_valid_i,
    input  logic [DEPTH*REG_AW-1:0] slot_rd_i,
    input  logic [DEPTH*LAT_W-1:0]  slot_lat_i,
    output logic [SEL_W-1:0]        sel_next_o,
    output logic                    not_ready_o
);

    // Scan oldest to youngest so the youngest matching slot has the last word
    always_comb begin
        sel_next_o  = SEL_W'(FWD_RF);
        not_ready_o = 1'b0;
        for (int j = int'(DEPTH) - 1; j >= 0; j--) begin
            if (used_i && (rs_i != '0) && slot_valid_i[j] &&
                (slot_rd_i[j*REG_AW +: REG_AW] == rs_i)) begin
                sel_next_o  = SEL_W'(j + 1);
                not_ready_o = (32'(j) + 32'd1) <= 32'(slot_lat_i[j*LAT_W +: LAT_W]);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: DEPTH-slot shift of in-flight writers, load-use stall
// and registered per-operand forward selects. FWD_STALL_CNT_EN adds a stall counter.
module fwd_scoreboard
    import pipe_defs::*;
#(
    parameter  int unsigned NUM_RS = 2,
    parameter  int unsigned DEPTH  = 3,
    parameter  int unsigned REG_AW = 5,
    parameter  int unsigned LAT_W  = 2,
    localparam int unsigned SEL_W  = sel_w(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     id_valid_i,
    input  logic [NUM_RS*REG_AW-1:0] id_rs_i,
    input  logic [NUM_RS-1:0]        id_rs_used_i,
    input  logic [REG_AW-1:0]        id_rd_i,
    input  logic                     id_write_reg_i,
    input  logic [LAT_W-1:0]         id_lat_i,
    input  logic                     flush_i,
    output logic                     stall_o,
    output logic [NUM_RS*SEL_W-1:0]  fwd_sel_o,
    output logic [31:0]              stall_cnt_o
);

    logic [DEPTH-1:0]        slot_valid_q, slot_valid_d;
    logic [DEPTH*REG_AW-1:0] slot_rd_q,    slot_rd_d;
    logic [DEPTH*LAT_W-1:0]  slot_lat_q,   slot_lat_d;
    logic [NUM_RS*SEL_W-1:0] fwd_sel_q,    fwd_sel_d;

    logic [SEL_W-1:0] lane_sel       [NUM_RS];
    logic             lane_not_ready [NUM_RS];
    logic             issue;

    for (genvar n = 0; n < NUM_RS; n++) begin : g_lane
        fwd_match_lane #(
            .DEPTH  (DEPTH),
            .REG_AW (REG_AW),
            .LAT_W  (LAT_W),
            .SEL_W  (SEL_W)
        ) u_lane (
            .rs_i         (id_rs_i[n*REG_AW +: REG_AW]),
            .used_i       (id_rs_used_i[n]),
            .slot_valid_i (slot_valid_q),
            .slot_rd_i    (slot_rd_q),
            .slot_lat_i   (slot_lat_q),
            .sel_next_o   (lane_sel[n]),
            .not_ready_o  (lane_not_ready[n])
        );
    end

    // Any operand waiting on an unfinished producer stalls; a flush overrides it
    always_comb begin
        stall_o = 1'b0;
        for (int n = 0; n < int'(NUM_RS); n++) begin
            stall_o = stall_o | lane_not_ready[n];
        end
        stall_o = stall_o && id_valid_i && !flush_i;
    end

    assign issue = id_valid_i && !stall_o && !flush_i;

    // Age every slot by one stage; slot0 takes the issuing instruction or a bubble
    always_comb begin
        slot_valid_d = '0;
        slot_rd_d    = '0;
        slot_lat_d   = '0;
        slot_valid_d[0]          = issue && id_write_reg_i && (id_rd_i != '0);
        slot_rd_d[REG_AW-1:0]    = id_rd_i;
        slot_lat_d[LAT_W-1:0]    = id_lat_i;
        for (int j = 1; j < int'(DEPTH); j++) begin
            slot_valid_d[j]                  = slot_valid_q[j-1];
            slot_rd_d[j*REG_AW +: REG_AW]    = slot_rd_q[(j-1)*REG_AW +: REG_AW];
            slot_lat_d[j*LAT_W +: LAT_W]     = slot_lat_q[(j-1)*LAT_W +: LAT_W];
        end
    end

    // Selects only follow an instruction that actually moves into EX
    always_comb begin
        fwd_sel_d = '0;
        if (issue) begin
            for (int n = 0; n < int'(NUM_RS); n++) begin
                fwd_sel_d[n*SEL_W +: SEL_W] = lane_sel[n];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_valid_q <= '0;
            slot_rd_q    <= '0;
            slot_lat_q   <= '0;
            fwd_sel_q    <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_rd_q    <= slot_rd_d;
            slot_lat_q   <= slot_lat_d;
            fwd_sel_q    <= fwd_sel_d;
        end
    end

    assign fwd_sel_o = fwd_sel_q;

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule
